or8_way: RTL and testbench
==========================

# or8_way

8-input OR reduction for the Hack gate library. It asserts its output whenever any of the eight input bits is 1. It is built structurally from the library's two-input gates and adds a registered copy of the result plus a sticky "any-seen" flag, so sequential logic can sample the reduction without a combinational path. It sits with the other multi-way gates (Or8Way family) and feeds the ALU zero/nonzero detection and CPU control logic.

## Interface
Parameters:
- none; width is fixed at 8.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all registered outputs immediately.
- in  input  8  operand bits in[7:0], treated as unsigned, no bit priority.
- clear  input  1  synchronous clear of `sticky`; active-high.
- out  output  1  combinational OR of in[7:0].
- out_q  output  1  `out` registered, one-cycle latency.
- sticky  output  1  set once `out_q` has been 1; held until cleared.

## Operation
- out = in[0] | in[1] | … | in[7]; out = 0 only when in == 8'b00000000.
- Only this reduction is computed; `out` does not depend on bit order, count or position.
- out_q: on each rising clock edge, out_q ← out.
- sticky: on each rising clock edge:
  - if clear = 1, sticky ← 0, and clear takes priority over set;
  - else if out_q = 1, sticky ← 1;
  - else sticky holds its value.
- reset = 1 forces out_q = 0 and sticky = 0 asynchronously, independent of clock.
  - While reset is high, registers stay 0 regardless of `in` or `clear`.
  - `out` stays purely combinational and keeps following `in` during reset.
- Deassertion of reset takes effect at the next rising edge. The first capture is that edge's value of `out`.
- X/Z on any `in` bit may produce X on `out`. No masking is required.

## Timing
- out: zero-cycle combinational, settles within the gate-tree delay. With unit-delay gates the depth is 3 OR levels.
- out_q: valid one cycle after `in` is stable before a rising edge.
- sticky: rises one cycle after out_q rises, so two edges after `in` first becomes nonzero.
- clear and a set condition in the same cycle: sticky = 0 after the edge. It re-sets on the following edge if out_q is still 1.
- Reset values: out_q = 0, sticky = 0. `out` has no reset value and reflects `in`.
- Reset mid-operation clears both registers within the same time step, without waiting for a clock edge.

## Structure
- Shared gate package/library (gates.v) provides Nand, Not, And and Or. The 8-way tree is built from them with no behavioural `|` reduction:
  - level 1: 4 Or gates on pairs (0,1), (2,3), (4,5), (6,7);
  - level 2: 2 Or gates;
  - level 3: 1 Or gate.
- One natural sub-module: `or8_way_tree` is the purely combinational reduction. It is reusable standalone and is instantiated by the Or16/Mux-based blocks.
- The top level adds two flip-flops (out_q, sticky) with asynchronous reset. No constants or typedefs are needed beyond the width 8.

## Test plan
- Combinational sweep, 50 time units per step, checking `out`:
  - in = 00000000 → out = 0;
  - 11111111 → 1;
  - 00010000 → 1;
  - 00000001 → 1;
  - 00100110 → 1.
- Registered path: hold reset 1, then release with in = 00000000. out_q = 0 and sticky = 0 for all edges. Then set in = 00010000: out_q = 1 after 1 edge, sticky = 1 after 2 edges.
- Sticky hold and clear: after sticky = 1, set in = 00000000.
  - out_q drops after 1 edge and sticky stays 1.
  - Pulse clear for one cycle: sticky = 0 after that edge.
- Clear vs set priority: in = 00000001 and out_q = 1, with clear held high → sticky stays 0. Release clear → sticky = 1 on the next edge.
- Asynchronous reset: with sticky = 1 and out_q = 1, assert reset between clock edges. Both read 0 at once, while `out` still equals the OR of `in`.
- Exhaustive: all 256 values of `in`. out = 1 except for 0x00, and out_q matches the previous cycle's `out` on every edge.

Source files
------------

// File: rtl/or8_way_pkg.sv
// Shared width for the 8-way OR reduction family.
// No state; imported by the interface, the gate tree and the top level.
package or8_way_pkg;
    localparam int WIDTH = 8;
endpackage

// File: rtl/or8_way_if.sv
// Operand/result bundle for or8_way; the slave side is the reduction block.
// Pure wiring; no flow control, every signal is valid every cycle.
interface or8_way_if;
    import or8_way_pkg::*;

    logic [WIDTH-1:0] in;
    logic             clear;
    logic             out;
    logic             out_q;
    logic             sticky;

    modport master (output in, output clear, input out, input out_q, input sticky);
    modport slave  (input in, input clear, output out, output out_q, output sticky);
endinterface

// File: rtl/gates.sv
// Two-input gate primitives; everything is derived from Nand.
// Zero-cycle combinational, no backpressure.
module Nand (
    input  logic a,
    input  logic b,
    output logic out
);
    assign out = ~(a & b);
endmodule

module Not (
    input  logic in,
    output logic out
);
    Nand u_nand (.a(in), .b(in), .out(out));
endmodule

module And (
    input  logic a,
    input  logic b,
    output logic out
);
    logic n;
    Nand u_nand (.a(a), .b(b), .out(n));
    Not  u_not  (.in(n), .out(out));
endmodule

module Or (
    input  logic a,
    input  logic b,
    output logic out
);
    logic na;
    logic nb;
    Not  u_na   (.in(a), .out(na));
    Not  u_nb   (.in(b), .out(nb));
    Nand u_nand (.a(na), .b(nb), .out(out));
endmodule

// File: rtl/or8_way_tree.sv
// Balanced 3-level Or-gate tree reducing 8 bits to one; reusable standalone.
// Zero-cycle combinational, no backpressure.
module or8_way_tree
    import or8_way_pkg::*;
(
    input  logic [WIDTH-1:0] in_i,
    output logic             out_o
);
    logic [3:0] l1;
    logic [1:0] l2;

    Or u_l1_0 (.a(in_i[0]), .b(in_i[1]), .out(l1[0]));
    Or u_l1_1 (.a(in_i[2]), .b(in_i[3]), .out(l1[1]));
    Or u_l1_2 (.a(in_i[4]), .b(in_i[5]), .out(l1[2]));
    Or u_l1_3 (.a(in_i[6]), .b(in_i[7]), .out(l1[3]));

    Or u_l2_0 (.a(l1[0]), .b(l1[1]), .out(l2[0]));
    Or u_l2_1 (.a(l1[2]), .b(l1[3]), .out(l2[1]));

    Or u_l3   (.a(l2[0]), .b(l2[1]), .out(out_o));
endmodule

// File: rtl/or8_way.sv
// 8-way OR with registered copy (1-cycle latency) and sticky any-seen flag.
// out is combinational; out_q/sticky clear asynchronously on reset; no backpressure.
module or8_way
    import or8_way_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    or8_way_if.slave      bus
);
    logic red;
    logic out_q_q;
    logic out_q_d;
    logic sticky_q;
    logic sticky_d;

    or8_way_tree u_tree (.in_i(bus.in), .out_o(red));

    // Clear beats set, so sticky re-arms only on the edge after clear drops.
    always_comb begin
        out_q_d  = red;
        sticky_d = sticky_q;
        if (bus.clear) begin
            sticky_d = 1'b0;
        end else if (out_q_q) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            out_q_q  <= out_q_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.out    = red;
    assign bus.out_q  = out_q_q;
    assign bus.sticky = sticky_q;
endmodule

// File: tb/tb_or8_way.sv
// Directed bench for or8_way: stimulus queues expectations, a monitor pops and compares.
module tb_or8_way;
    import or8_way_pkg::*;

    localparam int SIG_OUT    = 0;
    localparam int SIG_OUT_Q  = 1;
    localparam int SIG_STICKY = 2;

    typedef struct {
        string name;
        int    sig;
        logic  val;
    } exp_t;

    logic clock;
    logic reset;
    or8_way_if bus ();

    or8_way dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    event check_ev;
    int   n_vec;
    int   n_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_sig(input string name, input int sig, input logic val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> check_ev;
        #0;
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Monitor: drains every queued expectation when the stimulus signals a sample point.
    initial begin
        exp_t e;
        logic act;
        forever begin
            @(check_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sig)
                    SIG_OUT:   act = bus.out;
                    SIG_OUT_Q: act = bus.out_q;
                    default:   act = bus.sticky;
                endcase
                n_vec++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got %b, expected %b at t=%0t", e.name, act, e.val, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] comb_in [5];
        logic       comb_ex [5];
        n_vec = 0;
        n_err = 0;

        reset     = 1'b1;
        bus.in    = 8'h00;
        bus.clear = 1'b0;

        comb_in[0] = 8'b00000000; comb_ex[0] = 1'b0;
        comb_in[1] = 8'b11111111; comb_ex[1] = 1'b1;
        comb_in[2] = 8'b00010000; comb_ex[2] = 1'b1;
        comb_in[3] = 8'b00000001; comb_ex[3] = 1'b1;
        comb_in[4] = 8'b00100110; comb_ex[4] = 1'b1;

        #1;
        expect_sig("reset_out_q", SIG_OUT_Q, 1'b0);
        expect_sig("reset_sticky", SIG_STICKY, 1'b0);
        sample();

        // Combinational sweep while registers are held in reset.
        for (int i = 0; i < 5; i++) begin
            bus.in = comb_in[i];
            #50;
            expect_sig($sformatf("comb_out_%b", comb_in[i]), SIG_OUT, comb_ex[i]);
            expect_sig("comb_out_q_in_reset", SIG_OUT_Q, 1'b0);
            expect_sig("comb_sticky_in_reset", SIG_STICKY, 1'b0);
            sample();
        end

        // Registered path.
        step();
        bus.in = 8'h00;
        reset  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_sig("idle_out_q", SIG_OUT_Q, 1'b0);
            expect_sig("idle_sticky", SIG_STICKY, 1'b0);
            sample();
        end
        bus.in = 8'b00010000;
        step();
        expect_sig("rise_out_q_1edge", SIG_OUT_Q, 1'b1);
        expect_sig("rise_sticky_1edge", SIG_STICKY, 1'b0);
        sample();
        step();
        expect_sig("rise_out_q_2edge", SIG_OUT_Q, 1'b1);
        expect_sig("rise_sticky_2edge", SIG_STICKY, 1'b1);
        sample();

        // Sticky hold and clear.
        bus.in = 8'h00;
        step();
        expect_sig("hold_out_q", SIG_OUT_Q, 1'b0);
        expect_sig("hold_sticky", SIG_STICKY, 1'b1);
        sample();
        bus.clear = 1'b1;
        step();
        expect_sig("clear_sticky", SIG_STICKY, 1'b0);
        sample();
        bus.clear = 1'b0;
        step();
        expect_sig("after_clear_sticky", SIG_STICKY, 1'b0);
        sample();

        // Clear beats set.
        bus.in    = 8'b00000001;
        bus.clear = 1'b1;
        step();
        expect_sig("prio_out_q_a", SIG_OUT_Q, 1'b1);
        expect_sig("prio_sticky_a", SIG_STICKY, 1'b0);
        sample();
        step();
        expect_sig("prio_out_q_b", SIG_OUT_Q, 1'b1);
        expect_sig("prio_sticky_b", SIG_STICKY, 1'b0);
        sample();
        bus.clear = 1'b0;
        step();
        expect_sig("prio_release_sticky", SIG_STICKY, 1'b1);
        sample();

        // Asynchronous reset between edges.
        #1;
        expect_sig("pre_areset_out_q", SIG_OUT_Q, 1'b1);
        expect_sig("pre_areset_sticky", SIG_STICKY, 1'b1);
        sample();
        reset = 1'b1;
        #1;
        expect_sig("areset_out_q", SIG_OUT_Q, 1'b0);
        expect_sig("areset_sticky", SIG_STICKY, 1'b0);
        expect_sig("areset_out", SIG_OUT, 1'b1);
        sample();
        bus.in    = 8'h00;
        #1;
        expect_sig("areset_out_follows", SIG_OUT, 1'b0);
        sample();
        bus.in    = 8'hFF;
        bus.clear = 1'b1;
        step();
        expect_sig("reset_held_out_q", SIG_OUT_Q, 1'b0);
        expect_sig("reset_held_sticky", SIG_STICKY, 1'b0);
        expect_sig("reset_held_out", SIG_OUT, 1'b1);
        sample();
        bus.clear = 1'b0;
        reset     = 1'b0;
        step();
        expect_sig("first_capture_out_q", SIG_OUT_Q, 1'b1);
        sample();

        // Exhaustive sweep of all 256 operand values.
        for (int v = 0; v < 256; v++) begin
            bus.in = 8'(v);
            #1;
            expect_sig($sformatf("exh_out_%02h", v), SIG_OUT, (v != 0));
            sample();
            step();
            expect_sig($sformatf("exh_out_q_%02h", v), SIG_OUT_Q, (v != 0));
            sample();
        end

        #5;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
